flit_rx_buffer: RTL and testbench
=================================

FLIT_RX_BUFFER -- requirements
Module: flit_rx_buffer

Interface
REQ-001 Parameter FLIT_W, default 4, SHALL set the flit width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the buffer depth in flits; it SHALL be a power of two and at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 in_valid  input  1  SHALL mark a flit offered by the upstream sender this cycle.
REQ-006 in_flit  input  FLIT_W  SHALL carry the upstream flit, sampled when in_valid=1.
REQ-007 credit_out  output  1  SHALL be a one-cycle pulse returning one buffer credit to the upstream sender.
REQ-008 out_valid  output  1  SHALL indicate that out_flit holds the oldest stored flit.
REQ-009 out_flit  output  FLIT_W  SHALL present the head flit, or 0 when empty.
REQ-010 out_ready  input  1  SHALL indicate that the downstream consumer accepts the head flit this cycle.
REQ-011 count  output  $clog2(DEPTH)+1  SHALL report the number of stored flits.
REQ-012 overflow  output  1  SHALL be a sticky error flag for a flit arriving with no free slot.

Function
REQ-013 Storage SHALL be a DEPTH-entry circular buffer with write pointer, read pointer and occupancy counter.
REQ-014 A push SHALL occur when in_valid=1 and either count<DEPTH or a pop occurs in the same cycle.
REQ-015 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-016 A pushed flit SHALL be written at the write pointer, and the write pointer SHALL advance by 1 modulo DEPTH.
REQ-017 A pop SHALL advance the read pointer by 1 modulo DEPTH.
REQ-018 count SHALL increment on a push alone, decrement on a pop alone, and hold on push+pop or on neither.
REQ-019 Write-to-output latency SHALL be 1 cycle: a flit pushed at edge N becomes visible on out_flit after edge N.
REQ-020 There SHALL be no combinational path from in_flit to out_flit.
REQ-021 out_valid SHALL equal (count!=0), derived from registered state only.
REQ-022 out_flit and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 credit_out SHALL be registered and SHALL pulse for exactly one cycle in the cycle following each pop.
REQ-024 Back-to-back pops SHALL produce consecutive credit_out pulses, one per pop.
REQ-025 When in_valid=1, count=DEPTH and no pop occurs, the flit SHALL be dropped, the buffer SHALL be unchanged and overflow SHALL be set.
REQ-026 Once set, overflow SHALL remain set until reset.
REQ-027 With out_ready=1 while empty, no pop SHALL occur, the pointers SHALL be unchanged and credit_out SHALL stay 0.
REQ-028 Flits SHALL leave in arrival order, including across pointer wrap-around.

Reset
REQ-029 When rst=0 at a rising clk edge, both pointers, count, credit_out and overflow SHALL clear to 0.
REQ-030 After reset, out_valid SHALL be 0 and out_flit SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all stored flits and any pending credit pulse.
REQ-032 Storage contents need not be cleared on reset.
REQ-033 Reset SHALL take priority over a push or pop in the same cycle.

Structure
REQ-034 Package flit_pkg SHALL define FLIT_W, DEPTH, PTR_W=$clog2(DEPTH), CNT_W=PTR_W+1 and the flit_t typedef; this module and its senders SHALL share it.
REQ-035 Storage SHALL be a sub-module, flit_buf_mem: DEPTH x FLIT_W registers with one synchronous write port and one asynchronous read port.
REQ-036 Pointer, count, credit and overflow logic SHALL reside in flit_rx_buffer.

Verification
REQ-037 Reset, then push 0x1,0x2,0x3,0x4 with out_ready=0 -> count=4, out_flit=0x1, no credit_out, overflow=0.
REQ-038 From full, push 0x5 with out_ready=0 -> flit dropped, overflow=1 and stays 1, head still 0x1; then drain -> 0x1..0x4 in order, with 4 credit_out pulses each one cycle after its pop.
REQ-039 From full, push 0x9 with out_ready=1 in the same cycle -> 0x1 popped, 0x9 accepted, count stays 4, overflow=0, one credit pulse.
REQ-040 Stream 10 flits 0x0..0x9 with in_valid=1 and out_ready=1 continuously -> each flit appears one cycle after its push, in order across wrap, count never exceeds 1.
REQ-041 Push 0xA,0xB, then hold rst=0 for one cycle during a pop -> count=0, out_valid=0, no credit_out pulse after reset, overflow=0.
REQ-042 Hold out_ready=1 while empty for 3 cycles -> pointers unchanged, no credit_out, count=0.

Source files
------------

// File: rtl/flit_pkg.sv
// Shared flit definitions for the receive buffer and every sender that feeds it.
// Senders size their credit counters from DEPTH and CNT_W.
package flit_pkg;

   localparam int FLIT_W = 4;
   localparam int DEPTH  = 4;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/flit_rx_buffer_if.sv
// Upstream flit/credit and downstream valid/ready signals of the receive buffer.
// The master side is the environment; the slave side is the buffer.
interface flit_rx_buffer_if #(
   parameter int FLIT_W = flit_pkg::FLIT_W,
   parameter int DEPTH  = flit_pkg::DEPTH
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              in_valid;
   logic [FLIT_W-1:0] in_flit;
   logic              credit_out;
   logic              out_valid;
   logic [FLIT_W-1:0] out_flit;
   logic              out_ready;
   logic [CNT_W-1:0]  count;
   logic              overflow;

   modport master (
      output in_valid, in_flit, out_ready,
      input  credit_out, out_valid, out_flit, count, overflow
   );

   modport slave (
      input  in_valid, in_flit, out_ready,
      output credit_out, out_valid, out_flit, count, overflow
   );
endinterface

// File: rtl/flit_buf_mem.sv
// DEPTH x FLIT_W register file: one synchronous write port, one asynchronous read port.
// Contents are deliberately left out of reset.
module flit_buf_mem #(
   parameter int FLIT_W = flit_pkg::FLIT_W,
   parameter int DEPTH  = flit_pkg::DEPTH,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [FLIT_W-1:0] wdata,
   input  logic [PTR_W-1:0]  raddr,
   output logic [FLIT_W-1:0] rdata
);

   logic [FLIT_W-1:0] entries [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [FLIT_W-1:0] entry_reg;

         always_ff @(posedge clk) begin
            if (we && (waddr == PTR_W'(gi))) begin
               entry_reg <= wdata;
            end
         end

         assign entries[gi] = entry_reg;
      end
   endgenerate

   assign rdata = entries[raddr];

endmodule

// File: rtl/flit_rx_buffer.sv
// Credit-based flit receive buffer: circular store with in-order drain, a credit pulse
// per popped flit and a sticky overflow flag for flits sent without a credit.
module flit_rx_buffer #(
   parameter int FLIT_W = flit_pkg::FLIT_W,
   parameter int DEPTH  = flit_pkg::DEPTH
) (
   input  logic            clk,
   input  logic            rst,
   flit_rx_buffer_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              credit_reg, credit_next;
   logic              overflow_reg, overflow_next;
   logic              full, not_empty, push, pop;
   logic [FLIT_W-1:0] rd_data;

   assign full      = (count_reg == CNT_W'(DEPTH));
   assign not_empty = (count_reg != '0);
   assign pop       = not_empty & bus.out_ready;
   // A full buffer still takes a flit when the head leaves in the same cycle.
   assign push      = bus.in_valid & (~full | pop);

   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;
      credit_next   = pop;
      overflow_next = overflow_reg | (bus.in_valid & full & ~pop);

      if (push) begin
         wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
         count_next = count_reg + 1'b1;
      end else if (pop && !push) begin
         count_next = count_reg - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         credit_reg   <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         credit_reg   <= credit_next;
         overflow_reg <= overflow_next;
      end
   end

   flit_buf_mem #(
      .FLIT_W (FLIT_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_reg),
      .wdata (bus.in_flit),
      .raddr (rd_ptr_reg),
      .rdata (rd_data)
   );

   // Head is read from stored registers only, so in_flit never reaches out_flit in-cycle.
   assign bus.out_valid  = not_empty;
   assign bus.out_flit   = not_empty ? rd_data : '0;
   assign bus.count      = count_reg;
   assign bus.credit_out = credit_reg;
   assign bus.overflow   = overflow_reg;

endmodule

// File: tb/tb_flit_rx_buffer.sv
// Directed bench for flit_rx_buffer: vector table for fill/overflow/drain/empty-ready
// plus hand-written streaming and mid-operation reset sequences.
module tb_flit_rx_buffer;
   import flit_pkg::*;

   typedef struct {
      logic             rst;
      logic             in_valid;
      flit_t            in_flit;
      logic             out_ready;
      logic [CNT_W-1:0] exp_count;
      logic             exp_valid;
      flit_t            exp_flit;
      logic             exp_credit;
      logic             exp_overflow;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs [$];

   flit_rx_buffer_if bus ();

   flit_rx_buffer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic iv, input int fl, input logic ordy,
                      input int cnt, input logic v, input int ef, input logic cr,
                      input logic ov);
      vec_t t;
      t.rst = r; t.in_valid = iv; t.in_flit = flit_t'(fl); t.out_ready = ordy;
      t.exp_count = cnt[CNT_W-1:0]; t.exp_valid = v; t.exp_flit = flit_t'(ef);
      t.exp_credit = cr; t.exp_overflow = ov;
      vecs.push_back(t);
   endtask

   task automatic step(input logic r, input logic iv, input int fl, input logic ordy);
      rst           = r;
      bus.in_valid  = iv;
      bus.in_flit   = flit_t'(fl);
      bus.out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int cnt, input logic v, input int ef,
                            input logic cr, input logic ov);
      check({tag, ".count"},    int'(bus.count),      cnt);
      check({tag, ".valid"},    int'(bus.out_valid),  int'(v));
      check({tag, ".flit"},     int'(bus.out_flit),   ef);
      check({tag, ".credit"},   int'(bus.credit_out), int'(cr));
      check({tag, ".overflow"}, int'(bus.overflow),   int'(ov));
   endtask

   initial begin
      // rst iv fl or | count valid flit credit overflow
      add(0, 0, 0, 0,   0, 0, 0, 0, 0);     // reset
      add(1, 1, 1, 0,   1, 1, 1, 0, 0);     // fill 1..4, head stays 1
      add(1, 1, 2, 0,   2, 1, 1, 0, 0);
      add(1, 1, 3, 0,   3, 1, 1, 0, 0);
      add(1, 1, 4, 0,   4, 1, 1, 0, 0);
      add(1, 1, 5, 0,   4, 1, 1, 0, 1);     // dropped, overflow set
      add(1, 0, 6, 0,   4, 1, 1, 0, 1);     // sticky, head stable
      add(1, 0, 0, 1,   3, 1, 2, 1, 1);     // drain
      add(1, 0, 0, 1,   2, 1, 3, 1, 1);
      add(1, 0, 0, 1,   1, 1, 4, 1, 1);
      add(1, 0, 0, 1,   0, 0, 0, 1, 1);
      add(1, 0, 0, 1,   0, 0, 0, 0, 1);     // empty + ready: no credit
      add(0, 0, 0, 0,   0, 0, 0, 0, 0);     // reset clears overflow
      add(1, 1, 1, 0,   1, 1, 1, 0, 0);
      add(1, 1, 2, 0,   2, 1, 1, 0, 0);
      add(1, 1, 3, 0,   3, 1, 1, 0, 0);
      add(1, 1, 4, 0,   4, 1, 1, 0, 0);
      add(1, 1, 9, 1,   4, 1, 2, 1, 0);     // full push+pop: accepted
      add(1, 0, 0, 0,   4, 1, 2, 0, 0);
      add(1, 0, 0, 1,   3, 1, 3, 1, 0);
      add(1, 0, 0, 1,   2, 1, 4, 1, 0);
      add(1, 0, 0, 1,   1, 1, 9, 1, 0);     // 9 after wrap
      add(1, 0, 0, 1,   0, 0, 0, 1, 0);
      add(1, 0, 0, 1,   0, 0, 0, 0, 0);     // ready while empty x3
      add(1, 0, 0, 1,   0, 0, 0, 0, 0);
      add(1, 0, 0, 1,   0, 0, 0, 0, 0);
      add(1, 1, 7, 0,   1, 1, 7, 0, 0);     // pointers unchanged: 7 lands at head
      add(1, 0, 0, 1,   0, 0, 0, 1, 0);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].in_valid, int'(vecs[i].in_flit), vecs[i].out_ready);
         check_all($sformatf("vec%0d", i), int'(vecs[i].exp_count), vecs[i].exp_valid,
                   int'(vecs[i].exp_flit), vecs[i].exp_credit, vecs[i].exp_overflow);
         $display("vec%0d rst=%0d iv=%0d fl=%0h or=%0d -> cnt=%0d v=%0d fl=%0h cr=%0d ov=%0d",
                  i, vecs[i].rst, vecs[i].in_valid, vecs[i].in_flit, vecs[i].out_ready,
                  bus.count, bus.out_valid, bus.out_flit, bus.credit_out, bus.overflow);
      end

      // Continuous stream across pointer wrap: one-cycle latency, occupancy never above 1.
      step(0, 0, 0, 0);
      for (int k = 0; k < 10; k++) begin
         step(1, 1, k, 1);
         check_all($sformatf("stream%0d", k), 1, 1, k, (k > 0), 0);
         $display("stream%0d push=%0h -> out=%0h cnt=%0d cr=%0d",
                  k, k, bus.out_flit, bus.count, bus.credit_out);
      end
      step(1, 0, 0, 1);
      check_all("stream_end", 0, 0, 0, 1, 0);
      $display("stream_end -> cnt=%0d cr=%0d", bus.count, bus.credit_out);

      // Reset during a pop discards contents and the pending credit.
      step(0, 0, 0, 0);
      step(1, 1, 'hA, 0);
      step(1, 1, 'hB, 0);
      check_all("rst_pre", 2, 1, 'hA, 0, 0);
      step(0, 0, 0, 1);
      check_all("rst_mid", 0, 0, 0, 0, 0);
      step(1, 0, 0, 1);
      check_all("rst_post", 0, 0, 0, 0, 0);
      $display("rst_mid -> cnt=%0d v=%0d cr=%0d ov=%0d",
               bus.count, bus.out_valid, bus.credit_out, bus.overflow);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
